// File: rtl/qpmm_fp_canon.sv
// Sequential canonicalizer: reduces a redundant QPMM result into [0, MOD) by
// restoring conditional subtraction of MOD<<k, one step per cycle, k = N_STEP-1 down to 0.
module qpmm_fp_canon #(
   parameter int W_IN  = 268,
   parameter int W_MOD = 254,
   // BN254 base-field prime (the d0 modulus).
   parameter logic [W_MOD-1:0] MOD = 254'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
   parameter int N_STEP = W_IN - W_MOD + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_MOD-1:0] out_data
);

   localparam int KW = (N_STEP > 1) ? $clog2(N_STEP) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [W_IN:0]   r;
   logic [KW-1:0]   k;
   logic [W_IN:0]   mod_shift;
   logic [W_IN+1:0] diff;

   // One extra bit on the subtraction exposes the borrow that rejects a step.
   always_comb begin
      mod_shift = {{(W_IN + 1 - W_MOD){1'b0}}, MOD} << k;
      diff      = {1'b0, r} - {1'b0, mod_shift};
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = RUN;
         RUN:     if (k == '0)   state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         r     <= '0;
         k     <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  r <= {1'b0, in_data};
                  k <= KW'(N_STEP - 1);
               end
            end
            RUN: begin
               if (!diff[W_IN+1]) r <= diff[W_IN:0];
               if (k != '0)       k <= k - KW'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = r[W_MOD-1:0];

endmodule

// File: tb/tb_qpmm_fp_canon.sv
// Bench for qpmm_fp_canon: directed corner cases plus randomized ready/valid
// traffic checked against a plain x % MOD reference with an in-order queue.
module tb_qpmm_fp_canon;

   localparam int W_IN   = 268;
   localparam int W_MOD  = 254;
   localparam int N_STEP = W_IN - W_MOD + 1;
   localparam int N_RAND = 300;
   localparam logic [W_MOD-1:0] MOD =
      254'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W_IN-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [W_MOD-1:0] out_data;

   int checks;
   int errors;

   logic [W_IN-1:0] modw;
   logic [W_IN-1:0] expq[$];

   qpmm_fp_canon #(
      .W_IN  (W_IN),
      .W_MOD (W_MOD),
      .MOD   (MOD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W_IN-1:0] golden(input logic [W_IN-1:0] x);
      return x % modw;
   endfunction

   function automatic logic [W_IN-1:0] rand268();
      logic [287:0] v;
      v = '0;
      for (int i = 0; i < 9; i++) v = {v[255:0], 32'($urandom())};
      return v[W_IN-1:0];
   endfunction

   task automatic checkValue(input string tag, input logic [W_IN-1:0] obs,
                             input logic [W_IN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents x and holds it until the DUT takes it; returns on the negedge after the accept edge.
   task automatic applyStimulus(input logic [W_IN-1:0] x);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = x;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkValue("accept_timeout", 268'(n < 100), 268'(1));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Waits for the result, checks latency and value, then consumes it.
   task automatic checkOutput(input string tag, input logic [W_IN-1:0] exp);
      int cnt;
      cnt = 0;
      while (!out_valid && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      checkValue({tag, "_latency"}, 268'(cnt), 268'(N_STEP));
      checkValue({tag, "_data"}, 268'(out_data), exp);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkValue({tag, "_idle_after"}, 268'(in_ready), 268'(1));
   endtask

   initial begin
      logic [W_IN-1:0] x;
      logic [W_IN-1:0] x2;
      logic [W_IN-1:0] exp;
      logic [W_IN-1:0] j;
      int sent;
      int received;
      int cyc;
      bit in_take;
      bit out_take;

      checks    = 0;
      errors    = 0;
      modw      = 268'(MOD);
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkValue("reset_in_ready", 268'(in_ready), 268'(1));
      checkValue("reset_out_valid", 268'(out_valid), 268'(0));
      checkValue("reset_out_data", 268'(out_data), 268'(0));

      // Directed values.
      applyStimulus('0);
      checkOutput("zero", golden('0));
      applyStimulus(modw - 268'(1));
      checkOutput("mod_minus_1", modw - 268'(1));
      applyStimulus(modw);
      checkOutput("mod", 268'(0));
      applyStimulus(268'(2) * modw + 268'(5));
      checkOutput("two_mod_plus_5", 268'(5));
      x = '1;
      applyStimulus(x);
      checkOutput("all_ones", golden(x));

      // Backpressure: hold the result for 10 cycles while a new operand waits.
      x   = rand268();
      x2  = rand268();
      exp = golden(x);
      applyStimulus(x);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b1;
      in_data  = x2;
      for (int i = 0; i < 10; i++) begin
         checkValue("bp_out_valid", 268'(out_valid), 268'(1));
         checkValue("bp_out_data", 268'(out_data), exp);
         checkValue("bp_in_ready", 268'(in_ready), 268'(0));
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkValue("bp_in_ready_after", 268'(in_ready), 268'(1));
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("bp_second", golden(x2));

      // Reset in the middle of RUN.
      applyStimulus(rand268());
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkValue("midrst_out_valid", 268'(out_valid), 268'(0));
      checkValue("midrst_in_ready", 268'(in_ready), 268'(1));
      checkValue("midrst_out_data", 268'(out_data), 268'(0));
      applyStimulus(modw + 268'(1));
      checkOutput("after_reset", 268'(1));

      // Randomized traffic with gaps on both sides.
      sent     = 0;
      received = 0;
      cyc      = 0;
      while (received < N_RAND && cyc < 40000) begin
         if (!in_valid && sent < N_RAND && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 3))
               0: x = rand268() >> 14;
               1: begin
                  j = 268'($urandom_range(0, 16383));
                  x = j * modw;
               end
               default: x = rand268();
            endcase
            in_valid = 1'b1;
            in_data  = x;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         in_take   = in_valid && in_ready;
         out_take  = out_valid && out_ready;
         if (in_take) begin
            expq.push_back(golden(in_data));
            sent++;
         end
         if (out_take) begin
            if (expq.size() > 0) begin
               exp = expq.pop_front();
               checkValue("rand_data", 268'(out_data), exp);
            end else begin
               checkValue("rand_spurious_output", 268'(1), 268'(0));
            end
            received++;
         end
         @(negedge clk);
         if (in_take) in_valid = 1'b0;
         cyc++;
      end
      out_ready = 1'b0;
      checkValue("rand_completed", 268'(received), 268'(N_RAND));
      checkValue("rand_in_out_count", 268'(received), 268'(sent));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
